seq_detect_ctrl: RTL

//   Controller for the serial pattern detector path. Loads a programmable pattern
//   (length 1..PAT_W, MSB-first) through a valid/ready config handshake. Arms on

---
 rtl/seq_detect_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/seq_detect_ctrl.sv
// Serial pattern detector controller: programmable MSB-first pattern, match counting,
// target/abort completion. Optional ARMED idle timeout enabled by `define SEQ_DET_TIMEOUT_EN.
module seq_detect_ctrl #(
  parameter int PAT_W   = 4,
  parameter int LEN_W   = 3,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 1000,
  parameter int TO_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             abort,
  input  logic             i_valid,
  input  logic             i,
  output logic             o,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_DONE
  } state_t;

  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

  state_t           state_q;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [CNT_W-1:0] tgt_q;
  logic [PAT_W-1:0] sr_q;
  logic [LEN_W-1:0] fill_q;
  logic [CNT_W-1:0] cnt_q;
  logic             o_q;
  logic             done_q;
  logic             busy_q;
  logic             timeout_q;

  logic [LEN_W-1:0] len_eff;
  logic [PAT_W-1:0] mask;
  logic [PAT_W-1:0] sr_d;
  logic [LEN_W-1:0] fill_d;
  logic [CNT_W-1:0] cnt_d;
  logic             hit;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    len_eff = len_q;
    if (len_q == '0) begin
      len_eff = LEN_W'(1);
    end else if (len_q > PAT_W_L) begin
      len_eff = PAT_W_L;
    end

    mask = '0;
    for (int k = 0; k < PAT_W; k++) begin
      mask[k] = (LEN_W'(k) < len_eff);
    end

    sr_d   = {sr_q[PAT_W-2:0], i};
    fill_d = (fill_q >= PAT_W_L) ? PAT_W_L : fill_q + LEN_W'(1);
    cnt_d  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    hit    = i_valid && (fill_d >= len_eff) && (((sr_d ^ pat_q) & mask) == '0);
  end

`ifdef SEQ_DET_TIMEOUT_EN
  localparam logic [TO_W-1:0] TIMEOUT_L = TO_W'(TIMEOUT);
  logic [TO_W-1:0] to_q;
  logic [TO_W-1:0] to_d;
  assign to_d = to_q + TO_W'(1);
`else
  wire [TO_W-1:0] unused_timeout_cfg = TO_W'(TIMEOUT);
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      tgt_q     <= '0;
      sr_q      <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      o_q       <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
`ifdef SEQ_DET_TIMEOUT_EN
      to_q      <= '0;
`endif
    end else begin
      o_q       <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          // busy_q still set here means this is the done-pulse cycle; config/start wait one more cycle.
          if (busy_q) begin
            busy_q <= 1'b0;
          end else begin
            if (cfg_valid) begin
              pat_q <= cfg_pattern;
              len_q <= cfg_len;
              ovl_q <= cfg_overlap;
              tgt_q <= cfg_target;
            end
            if (start) begin
              state_q <= S_ARMED;
              busy_q  <= 1'b1;
              sr_q    <= '0;
              fill_q  <= '0;
              cnt_q   <= '0;
`ifdef SEQ_DET_TIMEOUT_EN
              to_q    <= '0;
`endif
            end
          end
        end

        S_ARMED: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (hit) begin
            sr_q   <= sr_d;
            fill_q <= ovl_q ? fill_d : '0;
            cnt_q  <= cnt_d;
            o_q    <= 1'b1;
`ifdef SEQ_DET_TIMEOUT_EN
            to_q   <= '0;
`endif
            if ((tgt_q != '0) && (cnt_d == tgt_q)) begin
              state_q <= S_DONE;
            end
          end else begin
            if (i_valid) begin
              sr_q   <= sr_d;
              fill_q <= fill_d;
            end
`ifdef SEQ_DET_TIMEOUT_EN
            to_q <= to_d;
            if (to_d == TIMEOUT_L) begin
              state_q   <= S_IDLE;
              busy_q    <= 1'b0;
              timeout_q <= 1'b1;
            end
`endif
          end
        end

        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready = ~busy_q;
  assign o         = o_q;
  assign match_cnt = cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef SEQ_DET_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule
